// File: rtl/core_irq_ctrl.sv
// core_irq_ctrl: external interrupt controller in front of core_top.
// It synchronizes NUM_SRC asynchronous interrupt lines and latches each one
// as an edge- or level-type pending bit. Pending sources are arbitrated by
// fixed priority (lowest index wins). One request at a time is presented to
// the core, with an acknowledge handshake and a timeout. A wake pulse is
// generated while the core sits in WFI.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   irq_src             raw asynchronous interrupt lines
//   irq_en              per-source enable
//   irq_ack             core acknowledge of the current request
//   core_wfi            core is in wait-for-interrupt
//   extenal_interrupt   registered request to the core
//   irq_id              index of the requested source, valid with the request
//   irq_pending         current pending bits, before the enable mask
//   core_wake           single-cycle wake pulse
//   ack_timeout_err     sticky flag: a request timed out
module core_irq_ctrl #(
  parameter int unsigned          NUM_SRC     = 4,
  parameter int unsigned          SYNC_STAGES = 2,
  parameter logic [NUM_SRC-1:0]   EDGE_MASK   = NUM_SRC'(4'b0011),
  parameter int unsigned          ACK_TIMEOUT = 255,
  localparam int unsigned         ID_W        = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic [NUM_SRC-1:0] irq_en,
  input  logic               irq_ack,
  input  logic               core_wfi,
  output logic               extenal_interrupt,
  output logic [ID_W-1:0]    irq_id,
  output logic [NUM_SRC-1:0] irq_pending,
  output logic               core_wake,
  output logic               ack_timeout_err
);

  localparam int unsigned      CNT_W    = $clog2(ACK_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_e;

  state_e             state_q, state_d;
  logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
  logic [NUM_SRC-1:0] s_d_q;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ext_q, ext_d;
  logic               err_q, err_d;
  logic               cond_q, wake_q;

  logic [NUM_SRC-1:0] s_sync;
  logic [NUM_SRC-1:0] elig;
  logic [NUM_SRC-1:0] ack_clr;
  logic [ID_W-1:0]    win;
  logic               wake_cond;

  assign s_sync    = sync_q[SYNC_STAGES-1];
  assign elig      = pend_q & irq_en;
  assign wake_cond = core_wfi & (|elig);

  // Multi-flop synchronizer plus one history flop for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      s_d_q <= '0;
    end else begin
      sync_q[0] <= irq_src;
      for (int unsigned k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      s_d_q <= s_sync;
    end
  end

  // Fixed priority: lowest eligible index wins
  always_comb begin
    win = '0;
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (elig[i]) win = ID_W'(i);
    end
  end

  // Request FSM: next state, latched id, timeout counter, sticky error
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    ack_clr = '0;
    case (state_q)
      IDLE: begin
        if (|elig) begin
          id_d    = win;
          cnt_d   = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (irq_ack) begin
          for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (ID_W'(i) == id_q) ack_clr[i] = 1'b1;
          end
          state_d = HOLD;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ext_d = (state_d == REQ);
  end

  // Edge bits: a new rising edge beats a simultaneous ack clear.
  // Level bits simply follow the synchronized line.
  assign pend_d = (EDGE_MASK & ((pend_q & ~ack_clr) | (s_sync & ~s_d_q)))
                | (~EDGE_MASK & s_sync);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
      ext_q   <= 1'b0;
      err_q   <= 1'b0;
      cond_q  <= 1'b0;
      wake_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      ext_q   <= ext_d;
      err_q   <= err_d;
      cond_q  <= wake_cond;
      wake_q  <= wake_cond & ~cond_q;
    end
  end

  assign extenal_interrupt = ext_q;
  assign irq_id            = id_q;
  assign irq_pending       = pend_q;
  assign core_wake         = wake_q;
  assign ack_timeout_err   = err_q;

endmodule
